hazard_scheduler: RTL and testbench
===================================

# hazard_scheduler

Pipeline hazard controller for the five-stage RISC-V core. It sits beside instruction_decode and sequences the IF/ID/EX/MEM/WB pipeline registers. It keeps a 3-entry scoreboard of in-flight destination registers for EX, MEM and WB. From that scoreboard and the decoded ID fields it raises stall, flush and freeze controls, and it produces registered forwarding selects for the EX-stage operand muxes.

## Interface
- No parameters; register index width is fixed at 5, opcode width at 7.
- `clk` input 1: single core clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `id_valid_i` input 1: ID stage holds a real instruction.
- `id_opcode_i` input 7: opcode from instruction_decode.
- `id_rd_i` input 5: destination register from instruction_decode.
- `id_rs1_i` input 5: source register 1; unused operands arrive as x0.
- `id_rs2_i` input 5: source register 2; unused operands arrive as x0.
- `ex_branch_taken_i` input 1: branch or jump in EX redirects the PC this cycle.
- `mem_ready_i` input 1: data memory completes the MEM-stage access this cycle.
- `stall_if_o` output 1: hold the PC and the IF/ID register.
- `stall_id_o` output 1: hold the ID stage.
- `flush_id_o` output 1: replace the IF/ID contents with a bubble.
- `flush_ex_o` output 1: load a bubble into ID/EX.
- `stall_all_o` output 1: freeze every pipeline register.
- `fwd_a_o` output 2: EX operand A select. 00 = regfile, 01 = EX/MEM result, 10 = MEM/WB result.
- `fwd_b_o` output 2: EX operand B select, same encoding as `fwd_a_o`.

## Operation
- ID instruction classes, from `id_opcode_i` using the `risc_v_pipeline_define.svh` opcodes:
  - is_load: opcode == `L`.
  - is_mem: opcode is `L` or `S`.
  - writes: opcode is not `S` or `B`, and rd != 0.
- Scoreboard entry per stage (EX, MEM, WB): {valid, rd, writes, is_load, is_mem}.
- A "match" requires: entry valid, entry writes, rs == entry rd, and rs != 0.
- FSM states:
  - RUN: the MEM stage holds no pending memory access.
  - MEM_WAIT: the MEM stage holds an is_mem entry.
- FSM transitions:
  - RUN -> MEM_WAIT when the pipeline advances and the EX entry is is_mem.
  - MEM_WAIT -> RUN when `mem_ready_i`=1 and the EX entry is not is_mem.
  - MEM_WAIT -> MEM_WAIT when `mem_ready_i`=1 and the EX entry is is_mem.
  - MEM_WAIT holds while `mem_ready_i`=0.
- Control priority, highest first:
  - freeze: state MEM_WAIT and `mem_ready_i`=0. `stall_all_o`=1; all other controls 0; scoreboard and forwarding registers hold.
  - branch flush: `ex_branch_taken_i`=1. `flush_id_o`=1 and `flush_ex_o`=1; no load-use stall, because the ID instruction is wrong-path.
  - load-use: an ID rs matches an EX entry with is_load. `stall_if_o`=1, `stall_id_o`=1, `flush_ex_o`=1.
- Advance means `stall_all_o`=0. On advance:
  - WB <= MEM and MEM <= EX.
  - EX <= bubble (valid=0) on flush, load-use stall, or `id_valid_i`=0; otherwise the ID fields.
- Forwarding, registered on advance for the instruction entering EX:
  - 01 if rs matches the EX entry.
  - else 10 if rs matches the MEM entry.
  - else 00.
  - Forced to 00 when a bubble enters EX.
- x0 never matches, so it never stalls and never forwards.

## Timing
- Reset: state RUN, all scoreboard entries invalid, `fwd_a_o`/`fwd_b_o` = 00. With `rst` held, every combinational output is 0.
- Stall, flush and freeze outputs are combinational from the state, the scoreboard and the current inputs; they are valid in the same cycle.
- Forward selects have one cycle of latency and are valid while the consumer sits in EX.
- Load-use costs exactly 1 bubble cycle. The consumer then forwards 10.
- Zero-wait memory (`mem_ready_i`=1 on the first MEM cycle) costs no freeze. N low cycles of `mem_ready_i` give N frozen cycles.
- If `ex_branch_taken_i` rises while frozen, the flush is applied only on the advancing cycle.
- `rst` asserted mid-freeze or mid-stall takes effect at the next edge and returns the block to reset values.

## Configuration
- `HAZARD_FWD_EN` defined: forwarding behaves as described above.
- `HAZARD_FWD_EN` undefined:
  - `fwd_a_o`/`fwd_b_o` are tied to 00.
  - Any match against EX, MEM or WB causes a load-use-style stall, repeated each cycle until clear. The regfile is not write-through, so the WB stage counts.
  - A back-to-back dependency costs 3 bubbles.

## Structure
- Shared package `risc_v_pipeline_pkg`:
  - `sb_entry_t` struct.
  - `fwd_sel_t` enum (FWD_RF=00, FWD_MEM=01, FWD_WB=10).
  - `hz_state_t` enum (RUN, MEM_WAIT).
- Opcode constants remain in `risc_v_pipeline_define.svh`.
- One sub-module, `hazard_match`: combinational rs-versus-entry compare, instantiated once per source/stage pair.

## Test plan
- Reset: `rst`=1 for 2 cycles -> all controls 0 and fwd 00; after release with `id_valid_i`=0, no stalls.
- `add x5,x1,x2` then `add x6,x5,x3` -> no stall; `fwd_a_o`=01 in the second instruction's EX cycle; `fwd_b_o`=00.
- `lw x5,0(x1)` then `add x6,x5,x0` -> one cycle with `stall_if_o`/`stall_id_o`/`flush_ex_o`=1, then `fwd_a_o`=10.
- `sw` entering MEM with `mem_ready_i` low for 3 cycles -> `stall_all_o`=1 for exactly 3 cycles; advance on the 4th; state returns to RUN.
- `ex_branch_taken_i`=1 while ID holds a load-use consumer -> `flush_id_o`=`flush_ex_o`=1 and `stall_if_o`=0.
- `add x0,x1,x2` then `add x6,x0,x0` -> fwd 00, no stall. Build without `HAZARD_FWD_EN`: `add x5` then `add x6,x5` -> 3 stall cycles.

Source files
------------

// File: rtl/risc_v_pipeline_pkg.sv
// ============================================================================
// Module   : risc_v_pipeline_pkg
// Purpose  : Shared types and opcode constants for the five-stage pipeline
//            hazard logic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package risc_v_pipeline_pkg;

    localparam int REG_W = 5;
    localparam int OPC_W = 7;

    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;

    // Scoreboard slot indices
    localparam int SB_EX  = 0;
    localparam int SB_MEM = 1;
    localparam int SB_WB  = 2;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             writes;
        logic             is_load;
        logic             is_mem;
    } sb_entry_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_t;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_t;

    localparam sb_entry_t SB_BUBBLE = '0;

    function automatic sb_entry_t sb_decode(input logic [OPC_W-1:0] opcode,
                                            input logic [REG_W-1:0] rd);
        sb_entry_t e;
        e.valid   = 1'b1;
        e.rd      = rd;
        e.is_load = (opcode == OPC_LOAD);
        e.is_mem  = (opcode == OPC_LOAD) || (opcode == OPC_STORE);
        e.writes  = !((opcode == OPC_STORE) || (opcode == OPC_BRANCH)) && (rd != '0);
        return e;
    endfunction

    // The younger producer (EX) wins over the older one (MEM).
    function automatic fwd_sel_t fwd_pick(input logic bubble,
                                          input logic hit_ex,
                                          input logic hit_mem);
        fwd_sel_t sel;
        sel = FWD_RF;
        if (!bubble) begin
            if (hit_ex) begin
                sel = FWD_MEM;
            end else if (hit_mem) begin
                sel = FWD_WB;
            end
        end
        return sel;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_match.sv
// ============================================================================
// Module   : hazard_match
// Purpose  : Compares one source register against one scoreboard entry.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_match
    import risc_v_pipeline_pkg::*;
(
    input  logic [REG_W-1:0] rs,
    input  sb_entry_t        entry,
    output logic             match
);

    logic w_unused;

    // x0 is hard-wired zero, so it can never depend on an in-flight write.
    assign match    = entry.valid && entry.writes && (rs == entry.rd) && (rs != '0);
    assign w_unused = ^{entry.is_load, entry.is_mem};

endmodule

`default_nettype wire

// File: rtl/hazard_scheduler.sv
// ============================================================================
// Module   : hazard_scheduler
// Purpose  : Stall/flush/freeze sequencing and registered EX forwarding
//            selects for the five-stage pipeline. Define HAZARD_FWD_EN to
//            enable forwarding; otherwise every RAW hazard stalls.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_scheduler
    import risc_v_pipeline_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid_i,
    input  logic [OPC_W-1:0] id_opcode_i,
    input  logic [REG_W-1:0] id_rd_i,
    input  logic [REG_W-1:0] id_rs1_i,
    input  logic [REG_W-1:0] id_rs2_i,
    input  logic             ex_branch_taken_i,
    input  logic             mem_ready_i,
    output logic             stall_if_o,
    output logic             stall_id_o,
    output logic             flush_id_o,
    output logic             flush_ex_o,
    output logic             stall_all_o,
    output logic [1:0]       fwd_a_o,
    output logic [1:0]       fwd_b_o
);

    sb_entry_t        r_sb_ex;
    sb_entry_t        r_sb_mem;
    sb_entry_t        r_sb_wb;
    hz_state_t        r_state;
    hz_state_t        w_state_nxt;

    sb_entry_t        w_stage [3];
    logic [REG_W-1:0] w_rs    [2];
    logic [2:0]       w_match [2];

    logic             w_hazard;
    logic             w_freeze;
    logic             w_flush;
    logic             w_stall;
    logic             w_advance;
    logic             w_bubble;
    logic             w_ex_mem;

    assign w_stage[SB_EX]  = r_sb_ex;
    assign w_stage[SB_MEM] = r_sb_mem;
    assign w_stage[SB_WB]  = r_sb_wb;
    assign w_rs[0]         = id_rs1_i;
    assign w_rs[1]         = id_rs2_i;

    generate
        for (genvar s = 0; s < 2; s++) begin : g_src
            for (genvar t = 0; t < 3; t++) begin : g_stage
                hazard_match u_match (
                    .rs    (w_rs[s]),
                    .entry (w_stage[t]),
                    .match (w_match[s][t])
                );
            end
        end
    endgenerate

`ifdef HAZARD_FWD_EN
    assign w_hazard = (w_match[0][SB_EX] | w_match[1][SB_EX]) & r_sb_ex.is_load;
`else
    // Without bypassing, the regfile write in WB is not visible to ID yet.
    assign w_hazard = (|w_match[0]) | (|w_match[1]);
`endif

    always_comb begin
        w_freeze  = !rst && (r_state == MEM_WAIT) && !mem_ready_i;
        w_flush   = !rst && !w_freeze && ex_branch_taken_i;
        w_stall   = !rst && !w_freeze && !ex_branch_taken_i && id_valid_i && w_hazard;
        w_advance = !w_freeze;
        w_bubble  = w_flush || w_stall || !id_valid_i;
        w_ex_mem  = r_sb_ex.valid && r_sb_ex.is_mem;
    end

    assign stall_all_o = w_freeze;
    assign stall_if_o  = w_stall;
    assign stall_id_o  = w_stall;
    assign flush_id_o  = w_flush;
    assign flush_ex_o  = w_flush || w_stall;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN: begin
                if (w_advance && w_ex_mem) begin
                    w_state_nxt = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (mem_ready_i) begin
                    w_state_nxt = w_ex_mem ? MEM_WAIT : RUN;
                end
            end
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= RUN;
            r_sb_ex  <= SB_BUBBLE;
            r_sb_mem <= SB_BUBBLE;
            r_sb_wb  <= SB_BUBBLE;
        end else begin
            r_state <= w_state_nxt;
            if (w_advance) begin
                r_sb_wb  <= r_sb_mem;
                r_sb_mem <= r_sb_ex;
                r_sb_ex  <= w_bubble ? SB_BUBBLE : sb_decode(id_opcode_i, id_rd_i);
            end
        end
    end

`ifdef HAZARD_FWD_EN
    fwd_sel_t r_fwd_a;
    fwd_sel_t r_fwd_b;

    // Current EX/MEM producers become MEM/WB once the consumer reaches EX.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fwd_a <= FWD_RF;
            r_fwd_b <= FWD_RF;
        end else if (w_advance) begin
            r_fwd_a <= fwd_pick(w_bubble, w_match[0][SB_EX], w_match[0][SB_MEM]);
            r_fwd_b <= fwd_pick(w_bubble, w_match[1][SB_EX], w_match[1][SB_MEM]);
        end
    end

    assign fwd_a_o = r_fwd_a;
    assign fwd_b_o = r_fwd_b;
`else
    assign fwd_a_o = FWD_RF;
    assign fwd_b_o = FWD_RF;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_scheduler.sv
// ============================================================================
// Module   : tb_hazard_scheduler
// Purpose  : Directed self-checking bench for hazard_scheduler; expectations
//            follow HAZARD_FWD_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_scheduler;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;

    // {stall_all, stall_if, stall_id, flush_id, flush_ex}
    localparam logic [4:0] C_IDLE   = 5'b00000;
    localparam logic [4:0] C_STALL  = 5'b01101;
    localparam logic [4:0] C_FLUSH  = 5'b00011;
    localparam logic [4:0] C_FREEZE = 5'b10000;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid_i;
    logic [6:0] id_opcode_i;
    logic [4:0] id_rd_i;
    logic [4:0] id_rs1_i;
    logic [4:0] id_rs2_i;
    logic       ex_branch_taken_i;
    logic       mem_ready_i;
    logic       stall_if_o;
    logic       stall_id_o;
    logic       flush_id_o;
    logic       flush_ex_o;
    logic       stall_all_o;
    logic [1:0] fwd_a_o;
    logic [1:0] fwd_b_o;

    int total = 0;
    int bad   = 0;

    string      tag_q [$];
    logic [8:0] exp_q [$];

    always #5 clk = ~clk;

    hazard_scheduler dut (
        .clk               (clk),
        .rst               (rst),
        .id_valid_i        (id_valid_i),
        .id_opcode_i       (id_opcode_i),
        .id_rd_i           (id_rd_i),
        .id_rs1_i          (id_rs1_i),
        .id_rs2_i          (id_rs2_i),
        .ex_branch_taken_i (ex_branch_taken_i),
        .mem_ready_i       (mem_ready_i),
        .stall_if_o        (stall_if_o),
        .stall_id_o        (stall_id_o),
        .flush_id_o        (flush_id_o),
        .flush_ex_o        (flush_ex_o),
        .stall_all_o       (stall_all_o),
        .fwd_a_o           (fwd_a_o),
        .fwd_b_o           (fwd_b_o)
    );

    task automatic drive(input logic v, input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic br, input logic mr);
        id_valid_i        = v;
        id_opcode_i       = op;
        id_rd_i           = rd;
        id_rs1_i          = rs1;
        id_rs2_i          = rs2;
        ex_branch_taken_i = br;
        mem_ready_i       = mr;
    endtask

    task automatic expect_out(input string tag, input logic [4:0] ctrl,
                              input logic [1:0] fa, input logic [1:0] fb);
        tag_q.push_back(tag);
        exp_q.push_back({ctrl, fa, fb});
    endtask

    task automatic tick();
        string      t;
        logic [8:0] e;
        logic [4:0] obs;
        @(negedge clk);
        if (tag_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_empty observed=0 entries expected=1");
        end else begin
            t   = tag_q.pop_front();
            e   = exp_q.pop_front();
            obs = {stall_all_o, stall_if_o, stall_id_o, flush_id_o, flush_ex_o};
            total++;
            assert (obs === e[8:4]) else begin
                bad++;
                $error("FAIL %s ctrl observed=%b expected=%b", t, obs, e[8:4]);
            end
            total++;
            assert (fwd_a_o === e[3:2]) else begin
                bad++;
                $error("FAIL %s fwd_a observed=%b expected=%b", t, fwd_a_o, e[3:2]);
            end
            total++;
            assert (fwd_b_o === e[1:0]) else begin
                bad++;
                $error("FAIL %s fwd_b observed=%b expected=%b", t, fwd_b_o, e[1:0]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input logic v, input logic [6:0] op,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic br, input logic mr,
                        input logic [4:0] ctrl, input logic [1:0] fa, input logic [1:0] fb);
        drive(v, op, rd, rs1, rs2, br, mr);
        expect_out(tag, ctrl, fa, fb);
        tick();
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            step(tag, 1'b0, OP_R, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, C_IDLE, 2'b00, 2'b00);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        drive(1'b0, OP_R, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        // Reset held with a taken branch and a stalled memory: all quiet.
        step("rst0", 1'b0, OP_R, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, C_IDLE, 2'b00, 2'b00);
        step("rst1", 1'b1, OP_R, 5'd5, 5'd1, 5'd2, 1'b1, 1'b0, C_IDLE, 2'b00, 2'b00);
        rst = 1'b0;
        idle("post_rst", 2);

        // ALU -> ALU dependency on rs1
        step("a_prod", 1'b1, OP_R, 5'd5, 5'd1, 5'd2, 1'b0, 1'b1, C_IDLE, 2'b00, 2'b00);
`ifdef HAZARD_FWD_EN
        step("a_cons", 1'b1, OP_R, 5'd6, 5'd5, 5'd3, 1'b0, 1'b1, C_IDLE, 2'b00, 2'b00);
        step("a_fwd",  1'b0, OP_R, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, C_IDLE, 2'b01, 2'b00);
`else
        for (int i = 0; i < 3; i++) begin
            step("a_stall", 1'b1, OP_R, 5'd6, 5'd5, 5'd3, 1'b0, 1'b1, C_STALL, 2'b00, 2'b00);
        end
        step("a_go",  1'b1, OP_R, 5'd6, 5'd5, 5'd3, 1'b0, 1'b1, C_IDLE, 2'b00, 2'b00);
        step("a_fwd", 1'b0, OP_R, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, C_IDLE, 2'b00, 2'b00);
`endif
        idle("a_drain", 3);

        // Load-use; the load then sees a zero-wait memory
        step("b_load", 1'b1, OP_LD, 5'd5, 5'd1, 5'd0, 1'b0, 1'b1, C_IDLE,  2'b00, 2'b00);
        step("b_use",  1'b1, OP_R,  5'd6, 5'd5, 5'd0, 1'b0, 1'b1, C_STALL, 2'b00, 2'b00);
`ifdef HAZARD_FWD_EN
        step("b_go",   1'b1, OP_R,  5'd6, 5'd5, 5'd0, 1'b0, 1'b1, C_IDLE,  2'b00, 2'b00);
        step("b_fwd",  1'b0, OP_R,  5'd0, 5'd0, 5'd0, 1'b0, 1'b1, C_IDLE,  2'b10, 2'b00);
`else
        step("b_s1",   1'b1, OP_R,  5'd6, 5'd5, 5'd0, 1'b0, 1'b1, C_STALL, 2'b00, 2'b00);
        step("b_s2",   1'b1, OP_R,  5'd6, 5'd5, 5'd0, 1'b0, 1'b1, C_STALL, 2'b00, 2'b00);
        step("b_go",   1'b1, OP_R,  5'd6, 5'd5, 5'd0, 1'b0, 1'b1, C_IDLE,  2'b00, 2'b00);
        step("b_fwd",  1'b0, OP_R,  5'd0, 5'd0, 5'd0, 1'b0, 1'b1, C_IDLE,  2'b00, 2'b00);
`endif
        idle("b_drain", 3);

        // Store waits 3 cycles in MEM; branch raised while frozen
        step("c_store", 1'b1, OP_ST, 5'd9, 5'd1, 5'd7, 1'b0, 1'b1, C_IDLE,   2'b00, 2'b00);
        step("c_ex",    1'b0, OP_R,  5'd0, 5'd0, 5'd0, 1'b0, 1'b1, C_IDLE,   2'b00, 2'b00);
        step("c_frz0",  1'b0, OP_R,  5'd0, 5'd0, 5'd0, 1'b0, 1'b0, C_FREEZE, 2'b00, 2'b00);
        step("c_frz1",  1'b0, OP_R,  5'd0, 5'd0, 5'd0, 1'b0, 1'b0, C_FREEZE, 2'b00, 2'b00);
        step("c_frz2",  1'b0, OP_R,  5'd0, 5'd0, 5'd0, 1'b1, 1'b0, C_FREEZE, 2'b00, 2'b00);
        step("c_adv",   1'b0, OP_R,  5'd0, 5'd0, 5'd0, 1'b1, 1'b1, C_FLUSH,  2'b00, 2'b00);
        step("c_run",   1'b0, OP_R,  5'd0, 5'd0, 5'd0, 1'b0, 1'b0, C_IDLE,   2'b00, 2'b00);
        idle("c_drain", 2);

        // Taken branch overrides the load-use stall of a wrong-path consumer
        step("d_load",  1'b1, OP_LD, 5'd5, 5'd1, 5'd0, 1'b0, 1'b1, C_IDLE,  2'b00, 2'b00);
        step("d_brn",   1'b1, OP_R,  5'd6, 5'd5, 5'd0, 1'b1, 1'b1, C_FLUSH, 2'b00, 2'b00);
        step("d_after", 1'b0, OP_R,  5'd0, 5'd0, 5'd0, 1'b0, 1'b1, C_IDLE,  2'b00, 2'b00);
        idle("d_drain", 2);

        // x0 never matches
        step("e_x0",  1'b1, OP_R, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1, C_IDLE, 2'b00, 2'b00);
        step("e_use", 1'b1, OP_R, 5'd6, 5'd0, 5'd0, 1'b0, 1'b1, C_IDLE, 2'b00, 2'b00);
        step("e_chk", 1'b0, OP_R, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, C_IDLE, 2'b00, 2'b00);
        idle("e_drain", 2);

        // rs2 dependency two instructions back
        step("f_p1", 1'b1, OP_R, 5'd7, 5'd1, 5'd2, 1'b0, 1'b1, C_IDLE, 2'b00, 2'b00);
        step("f_p2", 1'b1, OP_R, 5'd8, 5'd3, 5'd4, 1'b0, 1'b1, C_IDLE, 2'b00, 2'b00);
`ifdef HAZARD_FWD_EN
        step("f_cons", 1'b1, OP_R, 5'd9, 5'd1, 5'd7, 1'b0, 1'b1, C_IDLE, 2'b00, 2'b00);
        step("f_chk",  1'b0, OP_R, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, C_IDLE, 2'b00, 2'b10);
`else
        step("f_s0",   1'b1, OP_R, 5'd9, 5'd1, 5'd7, 1'b0, 1'b1, C_STALL, 2'b00, 2'b00);
        step("f_s1",   1'b1, OP_R, 5'd9, 5'd1, 5'd7, 1'b0, 1'b1, C_STALL, 2'b00, 2'b00);
        step("f_cons", 1'b1, OP_R, 5'd9, 5'd1, 5'd7, 1'b0, 1'b1, C_IDLE,  2'b00, 2'b00);
        step("f_chk",  1'b0, OP_R, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, C_IDLE,  2'b00, 2'b00);
`endif
        idle("f_drain", 3);

        // Reset asserted mid-freeze
        step("g_store", 1'b1, OP_ST, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1, C_IDLE,   2'b00, 2'b00);
        step("g_ex",    1'b0, OP_R,  5'd0, 5'd0, 5'd0, 1'b0, 1'b1, C_IDLE,   2'b00, 2'b00);
        step("g_frz",   1'b0, OP_R,  5'd0, 5'd0, 5'd0, 1'b0, 1'b0, C_FREEZE, 2'b00, 2'b00);
        rst = 1'b1;
        step("g_rst",   1'b0, OP_R,  5'd0, 5'd0, 5'd0, 1'b1, 1'b0, C_IDLE,   2'b00, 2'b00);
        rst = 1'b0;
        step("g_post",  1'b0, OP_R,  5'd0, 5'd0, 5'd0, 1'b0, 1'b0, C_IDLE,   2'b00, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
